mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Shares the single-port word memory between two requesters: a writer (decoder side) and a reader (test side).
- Sequences the memory's read/write strobes: rwn=1 is a read with a registered data_out; rwn=0 with start=1 is a write.
- Owns the memory's synchronous active-low clear. It runs a clear sequence after reset or on command, and returns read data with a fixed latency.

Parameters:
- ADDR_W, 16, address width; matches the memory's memory_size.
- DATA_W, 32, data word width.
- CLEAR_CYCLES, 1, cycles mem_reset_n is held low per clear sequence; must be >=1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wr_req  in  1  writer request; held with address and data until accepted.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle when wr_req && wr_ready.
- rd_req  in  1  reader request; held with address until accepted.
- rd_addr  in  ADDR_W  read address.
- rd_ready  out  1  read accepted this cycle when rd_req && rd_ready.
- rd_rsp_valid  out  1  one-cycle pulse; rd_rsp_data is valid in that cycle.
- rd_rsp_data  out  DATA_W  read data.
- clr_req  in  1  request a full memory clear.
- busy  out  1  high in every state except IDLE.
- mem_reset_n  out  1  drives the memory's reset input.
- mem_start  out  1  drives the memory's start input.
- mem_rwn  out  1  drives the memory's rwn input.
- mem_address_dec  out  ADDR_W  memory write address.
- mem_address_test  out  ADDR_W  memory read address.
- mem_data_in  out  DATA_W  memory write data.
- mem_data_out  in  DATA_W  memory read data.

Behaviour:
- Reset state:
  - Async reset forces state CLEAR and clear counter = 0.
  - All mem_* address/data outputs = 0; mem_start = 0, mem_rwn = 0, mem_reset_n = 0.
  - rd_rsp_valid = 0, busy = 1, last_grant = RD, so the writer wins the first tie.
- Registered outputs: all mem_* outputs are registered. Each is a decode of the current state plus latched address/data.
- States:
  - CLEAR: mem_reset_n = 0. Counter increments each cycle. After CLEAR_CYCLES cycles, go to IDLE.
  - IDLE: mem_reset_n = 1, mem_start = 0, mem_rwn = 0.
    - Priority: clr_req > arbitrated wr/rd. clr_req goes to CLEAR; both ready outputs are 0 that cycle.
    - If only one of wr_req/rd_req is asserted, it gets ready.
    - If both are asserted, the one not equal to last_grant gets ready (round-robin).
    - On accept: latch address/data, update last_grant, go to WR or RD.
  - WR (1 cycle): mem_start = 1, mem_rwn = 0, latched address and data driven. The memory writes on the edge ending WR. Next state IDLE.
  - RD (1 cycle): mem_rwn = 1, mem_start = 0, latched address driven. The memory updates data_out on the edge ending RD. Next state RSP.
  - RSP (1 cycle): mem_rwn = 0. rd_rsp_valid = 1 and rd_rsp_data = mem_data_out (combinational pass-through; stable because rwn = 0). Next state IDLE.
- Ready outputs: wr_ready and rd_ready are combinational, asserted only in IDLE, and never both in the same cycle.
- Latency:
  - Read accepted in cycle T: rd_rsp_valid in cycle T+2.
  - Write accepted in cycle T: mem_start high in cycle T+1.
  - Minimum request-to-request spacing: 2 cycles for a write, 3 cycles for a read.
- No response backpressure; the reader must take rd_rsp_valid when it comes.
- Requests and clr_req arriving during CLEAR/WR/RD/RSP are not lost, provided the requester holds them. clr_req is level-sampled in IDLE only.
- Reset mid-operation: an in-flight write may or may not land in memory. An in-flight read produces no response. A clear always follows reset, so memory contents are zero afterwards.
- Widths: the address and data paths pass through unchanged; no arithmetic except the clear counter, which is $clog2(CLEAR_CYCLES+1) bits.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs wr_grant_cnt[15:0] and rd_grant_cnt[15:0].
  - Each increments on its own accept and saturates at 16'hFFFF.
  - Both are cleared by reset and by entry into CLEAR.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg: state enum (CLEAR, IDLE, WR, RD, RSP), grant encoding constants (GNT_WR = 1'b0, GNT_RD = 1'b1), default width constants.
- One sub-module: mem_arb_rr2. Combinational 2-way round-robin pick: inputs req[1:0], last_grant, enable; outputs one-hot gnt[1:0].

Test Plan:
- Reset release with CLEAR_CYCLES=1 -> mem_reset_n low 1 cycle after reset drops, then busy=0; a read of address 0x0005 returns 32'h00000000.
- Write 0x1234 <- 32'hDEADBEEF, then read 0x1234 -> mem_start pulse with mem_address_dec=0x1234; rd_rsp_valid exactly 2 cycles after read accept with rd_rsp_data=32'hDEADBEEF.
- wr_req and rd_req held continuously from reset -> grants alternate WR, RD, WR, RD; neither requester gets two consecutive grants.
- clr_req asserted together with wr_req in IDLE -> CLEAR wins; the write is accepted after clear; a read of the previously written address returns 0 unless it is the new write.
- Async reset asserted during RD -> no rd_rsp_valid; outputs return to reset values immediately, without waiting for a clock edge.
- MEM_ARB_STATS_EN defined, 3 writes + 2 reads -> wr_grant_cnt=3, rd_grant_cnt=2; both return to 0 after clr_req.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared constants for the memory access arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam int DEF_ADDR_W       = 16;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_CLEAR_CYCLES = 1;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_CLEAR = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_WR    = 3'd2;
   localparam logic [2:0] ST_RD    = 3'd3;
   localparam logic [2:0] ST_RSP   = 3'd4;

   // Grant encoding doubles as the requester index into req/gnt vectors.
   localparam logic GNT_WR = 1'b0;
   localparam logic GNT_RD = 1'b1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr2.sv
// ============================================================================
// mem_arb_rr2 : combinational two-way round-robin pick, one-hot grant
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] gnt
);

   // On a tie the requester that was not served last wins.
   always_comb begin
      gnt    = 2'b00;
      gnt[0] = enable & req[0] & (~req[1] | (last_grant == GNT_RD));
      gnt[1] = enable & req[1] & (~req[0] | (last_grant == GNT_WR));
   end

endmodule

`default_nettype wire

// File: rtl/mem_access_arbiter.sv
// ============================================================================
// mem_access_arbiter : shares a single-port word memory between a writer and
//                      a reader, and sequences the memory's clear.
// Optional grant counters are enabled with `define MEM_ARB_STATS_EN.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ready,
   output logic              rd_rsp_valid,
   output logic [DATA_W-1:0] rd_rsp_data,
   input  logic              clr_req,
   output logic              busy,
   output logic              mem_reset_n,
   output logic              mem_start,
   output logic              mem_rwn,
   output logic [ADDR_W-1:0] mem_address_dec,
   output logic [ADDR_W-1:0] mem_address_test,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]       wr_grant_cnt,
   output logic [15:0]       rd_grant_cnt
`endif
);

   localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              mem_reset_n_q, mem_reset_n_d;
   logic              mem_start_q, mem_start_d;
   logic              mem_rwn_q, mem_rwn_d;
   logic [ADDR_W-1:0] addr_dec_q, addr_dec_d;
   logic [ADDR_W-1:0] addr_test_q, addr_test_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;

   logic [1:0]        gnt;
   logic              arb_en;

   assign arb_en = (state_q == ST_IDLE) && !clr_req;

   mem_arb_rr2 u_rr2 (
      .req        ({rd_req, wr_req}),
      .last_grant (last_grant_q),
      .enable     (arb_en),
      .gnt        (gnt)
   );

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      last_grant_d = last_grant_q;
      addr_dec_d   = addr_dec_q;
      addr_test_d  = addr_test_q;
      data_in_d    = data_in_q;

      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == CNT_LAST) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + CNT_W'(1);
            end
         end
         ST_IDLE: begin
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end else if (gnt[0]) begin
               state_d      = ST_WR;
               last_grant_d = GNT_WR;
               addr_dec_d   = wr_addr;
               data_in_d    = wr_data;
            end else if (gnt[1]) begin
               state_d      = ST_RD;
               last_grant_d = GNT_RD;
               addr_test_d  = rd_addr;
            end
         end
         ST_WR:   state_d = ST_IDLE;
         ST_RD:   state_d = ST_RSP;
         ST_RSP:  state_d = ST_IDLE;
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase

      // Memory strobes are registered decodes of the state being entered.
      mem_reset_n_d = (state_d != ST_CLEAR);
      mem_start_d   = (state_d == ST_WR);
      mem_rwn_d     = (state_d == ST_RD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_CLEAR;
         clr_cnt_q     <= '0;
         last_grant_q  <= GNT_RD;
         mem_reset_n_q <= 1'b0;
         mem_start_q   <= 1'b0;
         mem_rwn_q     <= 1'b0;
         addr_dec_q    <= '0;
         addr_test_q   <= '0;
         data_in_q     <= '0;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         last_grant_q  <= last_grant_d;
         mem_reset_n_q <= mem_reset_n_d;
         mem_start_q   <= mem_start_d;
         mem_rwn_q     <= mem_rwn_d;
         addr_dec_q    <= addr_dec_d;
         addr_test_q   <= addr_test_d;
         data_in_q     <= data_in_d;
      end
   end

   assign wr_ready         = gnt[0];
   assign rd_ready         = gnt[1];
   assign busy             = (state_q != ST_IDLE);
   // data_out is stable in RSP because rwn is already low again.
   assign rd_rsp_valid     = (state_q == ST_RSP);
   assign rd_rsp_data      = mem_data_out;
   assign mem_reset_n      = mem_reset_n_q;
   assign mem_start        = mem_start_q;
   assign mem_rwn          = mem_rwn_q;
   assign mem_address_dec  = addr_dec_q;
   assign mem_address_test = addr_test_q;
   assign mem_data_in      = data_in_q;

`ifdef MEM_ARB_STATS_EN
   logic [15:0] wr_cnt_q, wr_cnt_d;
   logic [15:0] rd_cnt_q, rd_cnt_d;

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (state_d == ST_CLEAR) begin
         wr_cnt_d = '0;
         rd_cnt_d = '0;
      end else begin
         if (state_q == ST_IDLE && state_d == ST_WR) wr_cnt_d = sat_inc16(wr_cnt_q);
         if (state_q == ST_IDLE && state_d == ST_RD) rd_cnt_d = sat_inc16(rd_cnt_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   assign wr_grant_cnt = wr_cnt_q;
   assign rd_grant_cnt = rd_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
// ============================================================================
// tb_mem_access_arbiter : directed bench with a behavioural single-port memory
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_req = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        wr_ready;
   logic        rd_req = 1'b0;
   logic [15:0] rd_addr = '0;
   logic        rd_ready;
   logic        rd_rsp_valid;
   logic [31:0] rd_rsp_data;
   logic        clr_req = 1'b0;
   logic        busy;
   logic        mem_reset_n;
   logic        mem_start;
   logic        mem_rwn;
   logic [15:0] mem_address_dec;
   logic [15:0] mem_address_test;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
`ifdef MEM_ARB_STATS_EN
   logic [15:0] wr_grant_cnt;
   logic [15:0] rd_grant_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_access_arbiter #(
      .ADDR_W       (16),
      .DATA_W       (32),
      .CLEAR_CYCLES (1)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .wr_req           (wr_req),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .wr_ready         (wr_ready),
      .rd_req           (rd_req),
      .rd_addr          (rd_addr),
      .rd_ready         (rd_ready),
      .rd_rsp_valid     (rd_rsp_valid),
      .rd_rsp_data      (rd_rsp_data),
      .clr_req          (clr_req),
      .busy             (busy),
      .mem_reset_n      (mem_reset_n),
      .mem_start        (mem_start),
      .mem_rwn          (mem_rwn),
      .mem_address_dec  (mem_address_dec),
      .mem_address_test (mem_address_test),
      .mem_data_in      (mem_data_in),
      .mem_data_out     (mem_data_out)
`ifdef MEM_ARB_STATS_EN
      ,
      .wr_grant_cnt     (wr_grant_cnt),
      .rd_grant_cnt     (rd_grant_cnt)
`endif
   );

   // Single-port memory: synchronous active-low clear, registered read data.
   logic [31:0] mem_arr [0:65535];
   always @(posedge clk) begin
      if (!mem_reset_n) begin
         for (int i = 0; i < 65536; i++) mem_arr[i] <= '0;
         mem_data_out <= '0;
      end else if (mem_rwn) begin
         mem_data_out <= mem_arr[mem_address_test];
      end else if (mem_start) begin
         mem_arr[mem_address_dec] <= mem_data_in;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench mid-way through the single CLEAR cycle after release.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_busy", busy, 1);
      chk("rst_mem_reset_n", mem_reset_n, 0);
      chk("rst_mem_start", mem_start, 0);
      chk("rst_mem_rwn", mem_rwn, 0);
      chk("rst_rsp_valid", rd_rsp_valid, 0);
      chk("rst_ready", {wr_ready, rd_ready}, 2'b00);
      chk("rst_addr_dec", mem_address_dec, 0);
      chk("rst_addr_test", mem_address_test, 0);
      chk("rst_data_in", mem_data_in, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("clr_busy", busy, 1);
      chk("clr_mem_reset_n", mem_reset_n, 0);
   endtask

   task automatic do_write(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      #1;
      chk("wr_ready", wr_ready, 1);
      chk("wr_rd_ready_excl", rd_ready, 0);
      @(negedge clk);
      wr_req = 1'b0;
      #1;
      chk("wr_mem_start", mem_start, 1);
      chk("wr_mem_rwn", mem_rwn, 0);
      chk("wr_addr_dec", mem_address_dec, a);
      chk("wr_data_in", mem_data_in, d);
      @(negedge clk);
      #1;
      chk("wr_done_start", mem_start, 0);
      chk("wr_done_busy", busy, 0);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      rd_req = 1'b1; rd_addr = a;
      #1;
      chk("rd_ready", rd_ready, 1);
      @(negedge clk);
      rd_req = 1'b0;
      #1;
      chk("rd_mem_rwn", mem_rwn, 1);
      chk("rd_addr_test", mem_address_test, a);
      chk("rd_early_valid", rd_rsp_valid, 0);
      @(negedge clk);
      #1;
      chk("rd_rsp_valid", rd_rsp_valid, 1);
      chk("rd_rsp_data", rd_rsp_data, d);
      chk("rd_rsp_rwn", mem_rwn, 0);
      @(negedge clk);
      #1;
      chk("rd_after_valid", rd_rsp_valid, 0);
      chk("rd_after_busy", busy, 0);
   endtask

   logic grants [0:3];
   int   n_grants;

   initial begin
      // Reset release and a read of cleared memory
      do_reset();
      @(negedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_mem_reset_n", mem_reset_n, 1);
      do_read(16'h0005, 32'h00000000);

      // Write then read back
      do_write(16'h1234, 32'hDEADBEEF);
      do_read(16'h1234, 32'hDEADBEEF);

      // clr_req beats a simultaneous write
      do_write(16'h0200, 32'h11112222);
      @(negedge clk);
      clr_req = 1'b1; wr_req = 1'b1; wr_addr = 16'h0300; wr_data = 32'h33334444;
      #1;
      chk("clr_prio_ready", {wr_ready, rd_ready}, 2'b00);
      @(negedge clk);
      clr_req = 1'b0;
      #1;
      chk("clr_state_mem_reset_n", mem_reset_n, 0);
      chk("clr_state_busy", busy, 1);
      chk("clr_state_wr_ready", wr_ready, 0);
      @(negedge clk);
      #1;
      chk("post_clr_wr_ready", wr_ready, 1);
      chk("post_clr_mem_reset_n", mem_reset_n, 1);
      @(negedge clk);
      wr_req = 1'b0;
      #1;
      chk("post_clr_start", mem_start, 1);
      chk("post_clr_addr_dec", mem_address_dec, 16'h0300);
      do_read(16'h0200, 32'h00000000);
      do_read(16'h1234, 32'h00000000);
      do_read(16'h0300, 32'h33334444);

      // Asynchronous reset while a read is in RD
      @(negedge clk);
      rd_req = 1'b1; rd_addr = 16'h0300;
      #1;
      chk("ar_rd_ready", rd_ready, 1);
      @(negedge clk);
      rd_req = 1'b0;
      #1;
      chk("ar_in_rd", mem_rwn, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_rwn_now", mem_rwn, 0);
      chk("ar_mem_reset_n_now", mem_reset_n, 0);
      chk("ar_busy_now", busy, 1);
      chk("ar_addr_test_now", mem_address_test, 0);
      chk("ar_valid_now", rd_rsp_valid, 0);
      @(negedge clk);
      #1;
      chk("ar_valid_held", rd_rsp_valid, 0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("ar_valid_after", rd_rsp_valid, 0);
      chk("ar_busy_after", busy, 0);
      do_read(16'h0300, 32'h00000000);

      // Both requesters held from reset: grants alternate, writer first
      wr_req = 1'b1; wr_addr = 16'h0100; wr_data = 32'hA5A50001;
      rd_req = 1'b1; rd_addr = 16'h0100;
      do_reset();
      n_grants = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         chk("rr_exclusive", {wr_ready, rd_ready} == 2'b11, 0);
         if (rd_rsp_valid) chk("rr_rsp_data", rd_rsp_data, 32'hA5A50001);
         if (wr_ready || rd_ready) begin
            if (n_grants < 4) grants[n_grants] = rd_ready;
            n_grants++;
         end
      end
      wr_req = 1'b0; rd_req = 1'b0;
      chk("rr_grant_count", n_grants, 5);
      chk("rr_g0_wr", grants[0], 0);
      chk("rr_g1_rd", grants[1], 1);
      chk("rr_g2_wr", grants[2], 0);
      chk("rr_g3_rd", grants[3], 1);

`ifdef MEM_ARB_STATS_EN
      do_reset();
      @(negedge clk);
      #1;
      chk("st_wr_cnt_rst", wr_grant_cnt, 0);
      chk("st_rd_cnt_rst", rd_grant_cnt, 0);
      do_write(16'h0010, 32'h00000001);
      do_write(16'h0011, 32'h00000002);
      do_read(16'h0010, 32'h00000001);
      do_write(16'h0012, 32'h00000003);
      do_read(16'h0012, 32'h00000003);
      chk("st_wr_cnt", wr_grant_cnt, 3);
      chk("st_rd_cnt", rd_grant_cnt, 2);
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      #1;
      chk("st_wr_cnt_clr", wr_grant_cnt, 0);
      chk("st_rd_cnt_clr", rd_grant_cnt, 0);
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
